cs_cmd_rx: RTL

Serial chip-select command receiver that sits directly upstream of the chip-select decoder. The MCU shifts a CS_IN_WIDTH-bit select code over three GPIO lines (clock, data, latch). This block synchronizes those lines into the 100 MHz domain, deserializes and frames the code, and presents it on `cs`. It then issues a clean, stretched `CS_READY` strobe whose rising edge always follows a stable `cs` value.

---
 rtl/cs_cmd_rx_pkg.sv | 24 ++
 rtl/cs_cmd_rx_sync_edge.sv | 40 ++++
 rtl/cs_cmd_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cs_cmd_rx_pkg.sv
// cs_cmd_rx_pkg: shared definitions for the serial chip-select receiver.
//   - FSM state encoding for the CS_READY strobe sequencer
//   - well-known chip-select codes
//   - default parameter values for cs_cmd_rx
package cs_cmd_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_HOLD  = 2'd3
   } cs_state_e;

   localparam logic [4:0] CS_NONE    = 5'h00;
   localparam logic [4:0] CS_FLASH   = 5'h1d;
   localparam logic [4:0] CS_MAX3421 = 5'h1e;

   localparam int DEF_CS_IN_WIDTH       = 5;
   localparam int DEF_READY_HIGH_CYCLES = 4;
   localparam int DEF_HOLD_CYCLES       = 4;
   localparam int DEF_TIMEOUT_CYCLES    = 10000;
   localparam int DEF_ERR_CNT_WIDTH     = 8;

endpackage

// File: rtl/cs_cmd_rx_sync_edge.sv
// sync_edge: two-flop synchronizer plus a history flop for rising-edge detect.
//   clk      in  system clock
//   reset    in  synchronous active-high reset
//   async_in in  asynchronous pin
//   sync_out out synchronized level (second stage)
//   rise     out high for one cycle when the synchronized level goes 0->1
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic hist_q, hist_d;

   always_comb begin
      s1_d   = async_in;
      s2_d   = s1_q;
      hist_d = s2_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         hist_q <= hist_d;
      end
   end

   assign sync_out = s2_q;
   assign rise     = s2_q & ~hist_q;

endmodule

// File: rtl/cs_cmd_rx.sv
// cs_cmd_rx: serial chip-select command receiver.
// Synchronizes the MCU's sclk/sdi/latch pins, deserializes a CS_IN_WIDTH-bit
// code (MSB first), frames it on the latch rise and hands it to the decoder as
// a registered cs value followed by a stretched CS_READY strobe.
//   clk, reset        system clock, synchronous active-high reset
//   cs_sclk/sdi/latch async serial pins from the MCU
//   cs                registered select code (changes only on IDLE->SETUP)
//   CS_READY          strobe, high READY_HIGH_CYCLES, rises 1 cycle after cs
//   busy              sequencer active or a frame waiting
//   frame_err         1-cycle pulse: bad bit count, timeout or overrun
//   err_cnt           saturating count of frame_err pulses
module cs_cmd_rx
   import cs_cmd_rx_pkg::*;
#(
   parameter int CS_IN_WIDTH       = DEF_CS_IN_WIDTH,
   parameter int READY_HIGH_CYCLES = DEF_READY_HIGH_CYCLES,
   parameter int HOLD_CYCLES       = DEF_HOLD_CYCLES,
   parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
   parameter int ERR_CNT_WIDTH     = DEF_ERR_CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cs_sclk,
   input  logic                     cs_sdi,
   input  logic                     cs_latch,
   output logic [CS_IN_WIDTH-1:0]   cs,
   output logic                     CS_READY,
   output logic                     busy,
   output logic                     frame_err,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

   localparam int BCW  = $clog2(CS_IN_WIDTH + 2);
   localparam int TCW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FMAX = (READY_HIGH_CYCLES > HOLD_CYCLES) ? READY_HIGH_CYCLES : HOLD_CYCLES;
   localparam int FCW  = $clog2(FMAX + 1);

   // synchronized pins
   logic sclk_s, sclk_rise, sdi_s, sdi_rise, latch_s, latch_rise;
   logic unused_sync;

   sync_edge u_sync_sclk  (.clk(clk), .reset(reset), .async_in(cs_sclk),  .sync_out(sclk_s),  .rise(sclk_rise));
   sync_edge u_sync_sdi   (.clk(clk), .reset(reset), .async_in(cs_sdi),   .sync_out(sdi_s),   .rise(sdi_rise));
   sync_edge u_sync_latch (.clk(clk), .reset(reset), .async_in(cs_latch), .sync_out(latch_s), .rise(latch_rise));

   assign unused_sync = sclk_s ^ sdi_rise ^ latch_s;

   // deserializer / framer state
   logic [CS_IN_WIDTH-1:0]   sr_q, sr_d;
   logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
   logic                     tmo_act_q, tmo_act_d;
   logic [TCW-1:0]           tmo_cnt_q, tmo_cnt_d;
   logic                     pending_q, pending_d;
   logic [CS_IN_WIDTH-1:0]   pending_code_q, pending_code_d;
   logic                     ferr_q, ferr_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   // strobe sequencer state
   cs_state_e                state_q, state_d;
   logic [FCW-1:0]           fsm_cnt_q, fsm_cnt_d;
   logic [CS_IN_WIDTH-1:0]   cs_q, cs_d;
   logic                     ready_q, ready_d;

   logic                     consume;

   assign consume = (state_q == ST_IDLE) && pending_q;

   // framer: shift, count, timeout, latch commit
   always_comb begin
      sr_d           = sr_q;
      bit_cnt_d      = bit_cnt_q;
      tmo_act_d      = tmo_act_q;
      tmo_cnt_d      = tmo_cnt_q;
      pending_d      = pending_q;
      pending_code_d = pending_code_q;
      ferr_d         = 1'b0;
      err_cnt_d      = err_cnt_q;

      if (consume)
         pending_d = 1'b0;

      if (tmo_act_q)
         tmo_cnt_d = tmo_cnt_q + 1'b1;

      if (sclk_rise) begin
         sr_d      = {sr_q[CS_IN_WIDTH-2:0], sdi_s};
         tmo_act_d = 1'b1;
         if (bit_cnt_q != BCW'(CS_IN_WIDTH + 1))
            bit_cnt_d = bit_cnt_q + 1'b1;
      end

      // Latch uses the post-shift count and beats a same-cycle timeout.
      if (latch_rise) begin
         if (bit_cnt_d == BCW'(CS_IN_WIDTH)) begin
            pending_code_d = sr_d;
            pending_d      = 1'b1;
            // overrun only if the old frame is not leaving this very cycle
            if (pending_q && !consume)
               ferr_d = 1'b1;
         end else begin
            ferr_d = 1'b1;
         end
         bit_cnt_d = '0;
         tmo_act_d = 1'b0;
         tmo_cnt_d = '0;
      end else if (tmo_act_q && (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1))) begin
         sr_d      = '0;
         bit_cnt_d = '0;
         tmo_act_d = 1'b0;
         tmo_cnt_d = '0;
         ferr_d    = 1'b1;
      end

      if (ferr_d && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}}))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   // sequencer: cs load, setup cycle, stretched strobe, hold
   always_comb begin
      state_d   = state_q;
      fsm_cnt_d = fsm_cnt_q;
      cs_d      = cs_q;
      ready_d   = ready_q;
      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               cs_d    = pending_code_q;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            ready_d   = 1'b1;
            fsm_cnt_d = '0;
            state_d   = ST_HIGH;
         end
         ST_HIGH: begin
            if (fsm_cnt_q == FCW'(READY_HIGH_CYCLES - 1)) begin
               ready_d   = 1'b0;
               fsm_cnt_d = '0;
               state_d   = ST_HOLD;
            end else begin
               fsm_cnt_d = fsm_cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (fsm_cnt_q == FCW'(HOLD_CYCLES - 1)) begin
               fsm_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               fsm_cnt_d = fsm_cnt_q + 1'b1;
            end
         end
         default: begin
            ready_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q           <= '0;
         bit_cnt_q      <= '0;
         tmo_act_q      <= 1'b0;
         tmo_cnt_q      <= '0;
         pending_q      <= 1'b0;
         pending_code_q <= '0;
         ferr_q         <= 1'b0;
         err_cnt_q      <= '0;
         state_q        <= ST_IDLE;
         fsm_cnt_q      <= '0;
         cs_q           <= '0;
         ready_q        <= 1'b0;
      end else begin
         sr_q           <= sr_d;
         bit_cnt_q      <= bit_cnt_d;
         tmo_act_q      <= tmo_act_d;
         tmo_cnt_q      <= tmo_cnt_d;
         pending_q      <= pending_d;
         pending_code_q <= pending_code_d;
         ferr_q         <= ferr_d;
         err_cnt_q      <= err_cnt_d;
         state_q        <= state_d;
         fsm_cnt_q      <= fsm_cnt_d;
         cs_q           <= cs_d;
         ready_q        <= ready_d;
      end
   end

   assign cs        = cs_q;
   assign CS_READY  = ready_q;
   assign busy      = (state_q != ST_IDLE) || pending_q;
   assign frame_err = ferr_q;
   assign err_cnt   = err_cnt_q;

endmodule
